// File: rtl/control_sequencer.sv
// control_sequencer: instruction-cycle sequencer for a simple register datapath.
// Steps IDLE -> T0..T5 (fetch, decode, ALU execute, writeback) and parks in HALT.
// Every strobe is a Moore decode of the state register and the IR field inputs.
module control_sequencer (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        Running,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // NOP (11010) and every unlisted opcode take the default "do nothing" path.
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_is_alu;
    logic        w_is_halt;
    logic        w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_is_alu    = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                         (w_opcode == OP_AND) || (w_opcode == OP_OR);
    assign w_is_halt   = (w_opcode == OP_HALT);
    assign w_unused_ir = &{1'b0, IR[14:0]};

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // State register; reset abandons any instruction in flight and returns to IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode; everything defaults low so IDLE/reset are quiet.
    always_comb begin
        w_next  = r_state;
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        Rout    = 16'h0000;
        Rin     = 16'h0000;
        Running = 1'b0;
        Halted  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) w_next = S_T0;
            end
            S_T0: begin
                Running = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                w_next  = S_T1;
            end
            S_T1: begin
                // Strobes stay up through a memory stall; PC reloads the same Zlow each cycle.
                Running = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (Mem_ready) w_next = S_T2;
            end
            S_T2: begin
                Running = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                w_next  = S_T3;
            end
            S_T3: begin
                // Decode point: the freshly loaded IR selects execute, halt or skip.
                Running = 1'b1;
                if (w_is_alu) begin
                    Rout   = onehot(w_rb);
                    Yin    = 1'b1;
                    w_next = S_T4;
                end else if (w_is_halt) begin
                    w_next = S_HALT;
                end else begin
                    w_next = Run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                Running = 1'b1;
                Rout    = onehot(w_rc);
                Zin     = 1'b1;
                ADD     = (w_opcode == OP_ADD);
                SUB     = (w_opcode == OP_SUB);
                AND     = (w_opcode == OP_AND);
                OR      = (w_opcode == OP_OR);
                w_next  = S_T5;
            end
            S_T5: begin
                Running = 1'b1;
                Zlowout = 1'b1;
                Rin     = onehot(w_ra);
                w_next  = Run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer.
// Stimulus expands each instruction into its expected per-cycle strobe trace and
// queues it; a negedge monitor pops one entry per cycle and compares.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic        Mem_ready;
    logic [31:0] IR;
    logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic        ADD, SUB, AND, OR;
    logic [15:0] Rout, Rin;
    logic        Running, Halted;

    control_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Rout(Rout), .Rin(Rin),
        .Running(Running), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    // Packed view of every output, bit positions fixed by the masks below.
    logic [48:0] w_act;
    assign w_act = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                    ADD, SUB, AND, OR, Rout, Rin, Running, Halted};

    localparam logic [48:0] B_HALTED  = 49'h1 << 0;
    localparam logic [48:0] B_RUNNING = 49'h1 << 1;
    localparam logic [48:0] B_READ    = 49'h1 << 38;
    localparam logic [48:0] B_INCPC   = 49'h1 << 39;
    localparam logic [48:0] B_YIN     = 49'h1 << 40;
    localparam logic [48:0] B_IRIN    = 49'h1 << 41;
    localparam logic [48:0] B_MDRIN   = 49'h1 << 42;
    localparam logic [48:0] B_PCIN    = 49'h1 << 43;
    localparam logic [48:0] B_ZIN     = 49'h1 << 44;
    localparam logic [48:0] B_MARIN   = 49'h1 << 45;
    localparam logic [48:0] B_MDROUT  = 49'h1 << 46;
    localparam logic [48:0] B_ZLOWOUT = 49'h1 << 47;
    localparam logic [48:0] B_PCOUT   = 49'h1 << 48;
    localparam logic [48:0] V_ZERO    = 49'h0;

    typedef struct {
        logic [48:0] v;
        string       nm;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   in_idle;

    function automatic logic [48:0] rout_bit(input logic [3:0] i);
        logic [48:0] t;
        t = '0;
        t[18 + i] = 1'b1;
        return t;
    endfunction

    function automatic logic [48:0] rin_bit(input logic [3:0] i);
        logic [48:0] t;
        t = '0;
        t[2 + i] = 1'b1;
        return t;
    endfunction

    // ALU opcodes 3..6 map to ADD,SUB,AND,OR (bits 37 down to 34).
    function automatic logic [48:0] alu_bit(input logic [4:0] op);
        logic [48:0] t;
        t = '0;
        t[40 - int'(op)] = 1'b1;
        return t;
    endfunction

    // 0 = ALU, 1 = NOP/undefined, 2 = HALT
    function automatic int op_kind(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd6) return 0;
        if (op == 5'd27) return 2;
        return 1;
    endfunction

    task automatic check(input string nm, input logic [48:0] act, input logic [48:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs for the current cycle, queue the expected outputs, advance one cycle.
    task automatic step(input logic run, input logic memr, input logic [48:0] v, input string nm);
        exp_t e;
        Run       = run;
        Mem_ready = memr;
        e.v  = v;
        e.nm = nm;
        expq.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // rm: 0 = Run high mid-instruction, 1 = Run random, 2 = Run low from T2 on.
    function automatic logic mid_run(input int rm, input bit late);
        if (rm == 0) return 1'b1;
        if (rm == 2) return late ? 1'b0 : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_instr(input logic [31:0] ir, input int stalls, input logic run_exit,
                            input int rm, input bit abort_t4, input int halt_cycles);
        logic [4:0] op;
        exp_t       e;
        op = ir[31:27];
        if (in_idle) step(1'b1, 1'($urandom_range(0, 1)), V_ZERO, "idle");
        step(mid_run(rm, 0), 1'($urandom_range(0, 1)),
             B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUNNING, "t0");
        for (int s = 0; s < stalls; s++)
            step(mid_run(rm, 0), 1'b0, B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUNNING, "t1_stall");
        step(mid_run(rm, 0), 1'b1, B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUNNING, "t1");
        IR = ir;
        step(mid_run(rm, 1), 1'($urandom_range(0, 1)), B_MDROUT | B_IRIN | B_RUNNING, "t2");
        case (op_kind(op))
            0: begin
                step(mid_run(rm, 1), 1'($urandom_range(0, 1)),
                     rout_bit(ir[22:19]) | B_YIN | B_RUNNING, "t3_alu");
                if (abort_t4) begin
                    Run = mid_run(rm, 1);
                    e.v  = rout_bit(ir[18:15]) | B_ZIN | alu_bit(op) | B_RUNNING;
                    e.nm = "t4_before_rst";
                    expq.push_back(e);
                    @(negedge Clock);
                    #1;
                    Resetn = 1'b0;
                    #1;
                    check("async_rst_t4", w_act, V_ZERO);
                    @(posedge Clock);
                    #1;
                    step(1'b1, 1'b1, V_ZERO, "rst_hold_no_rin");
                    Resetn = 1'b1;
                    in_idle = 1'b1;
                    step(1'b0, 1'b1, V_ZERO, "idle_after_rst");
                    return;
                end
                step(mid_run(rm, 1), 1'($urandom_range(0, 1)),
                     rout_bit(ir[18:15]) | B_ZIN | alu_bit(op) | B_RUNNING, "t4");
                step(run_exit, 1'($urandom_range(0, 1)),
                     B_ZLOWOUT | rin_bit(ir[26:23]) | B_RUNNING, "t5");
                in_idle = !run_exit;
            end
            1: begin
                step(run_exit, 1'($urandom_range(0, 1)), B_RUNNING, "t3_nop");
                in_idle = !run_exit;
            end
            default: begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), B_RUNNING, "t3_halt");
                for (int h = 0; h < halt_cycles; h++)
                    step(1'b1, 1'($urandom_range(0, 1)), B_HALTED, "halt");
                Resetn = 1'b0;
                step(1'b1, 1'b1, V_ZERO, "halt_rst");
                Resetn = 1'b1;
                in_idle = 1'b1;
                step(1'b0, 1'b1, V_ZERO, "idle_after_halt");
            end
        endcase
    endtask

    // Monitor: one expected entry per cycle, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check(e.nm, w_act, e.v);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        logic [4:0]  op;
        int          pick;
        Resetn    = 1'b0;
        Run       = 1'b1;
        Mem_ready = 1'b0;
        IR        = 32'h0;
        in_idle   = 1'b1;
        @(posedge Clock);
        #1;
        // Reset held with Run high: nothing moves.
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), V_ZERO, "in_reset");
        Resetn = 1'b1;

        // AND r1 = r2 & r3, no stall.
        do_instr(32'h28918000, 0, 1'b1, 0, 1'b0, 0);
        // Three-cycle memory stall on an AND.
        do_instr(32'h28918000, 3, 1'b1, 0, 1'b0, 0);
        // Run dropped from T2 of a SUB: completes, then IDLE.
        do_instr({5'b00100, 4'd5, 4'd6, 4'd7, 15'h0}, 1, 1'b0, 2, 1'b0, 0);
        step(1'b0, 1'b0, V_ZERO, "idle_run_low");
        // ADD aborted by reset in T4.
        do_instr({5'b00011, 4'd9, 4'd10, 4'd11, 15'h1234}, 0, 1'b1, 0, 1'b1, 0);
        // Explicit NOP and HALT.
        do_instr({5'b11010, 27'h0}, 0, 1'b1, 0, 1'b0, 0);
        do_instr(32'hD8000000, 0, 1'b1, 0, 1'b0, 5);

        // Randomized instruction mix.
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 60) op = 5'($urandom_range(3, 6));
            else if (pick < 75) op = 5'b11010;
            else if (pick < 93) begin
                op = 5'($urandom_range(0, 31));
                while (op_kind(op) != 1) op = 5'($urandom_range(0, 31));
            end else op = 5'b11011;
            ir = {op, 27'($urandom)};
            do_instr(ir, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1,
                     (op_kind(op) == 0) && ($urandom_range(0, 9) == 0), $urandom_range(1, 4));
        end

        @(negedge Clock);
        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge Clock);
        #1;
        if (expq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have these ports, clock and reset first (name  direction  width  meaning):
- Clock  in  1  single system clock; all state updates occur on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  level; enables instruction sequencing.
- Mem_ready  in  1  memory read data valid in the current cycle.
- IR  in  32  instruction register contents from the datapath.
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath control strobes.
- ADD, SUB, AND, OR  out  1 each  ALU operation selects.
- Rout  out  16  one-hot general register output enable.
- Rin  out  16  one-hot general register load enable.
- Running  out  1  high in any state T0..T5.
- Halted  out  1  high in state HALT.
REQ-002 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-003 States SHALL be IDLE, T0, T1, T2, T3, T4, T5 and HALT, held in one registered state variable.
REQ-004 All outputs SHALL be Moore outputs decoded from the state and IR only, with no registered strobes.
REQ-005 IR fields SHALL be: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-006 Opcode encodings SHALL be: ADD 00011, SUB 00100, AND 00101, OR 00110, NOP 11010, HALT 11011; every other opcode SHALL be executed as NOP.
REQ-007 IDLE SHALL assert no strobes; the next state SHALL be T0 if Run=1, else IDLE.
REQ-008 T0 SHALL assert PCout, MARin, IncPC and Zin; the next state SHALL be T1 unconditionally.
REQ-009 T1 SHALL assert Zlowout, PCin, Read and MDRin; the next state SHALL be T2 if Mem_ready=1, else T1.
- While stalling, all four strobes SHALL stay high every stall cycle.
- The PC SHALL be reloaded with the same Zlow value on each stall cycle.
REQ-010 T2 SHALL assert MDRout and IRin; the next state SHALL be decided on the opcode of the IR value loaded during T2, sampled on the edge that leaves T3:
- T2 SHALL always advance to T3.
- T3 SHALL act as the decode point (REQ-011, REQ-014).
REQ-011 For ALU opcodes, T3 SHALL assert Rout[Rb] and Yin, and the next state SHALL be T4.
REQ-012 T4 SHALL assert Rout[Rc], Zin, and exactly one of ADD/SUB/AND/OR matching the opcode; the next state SHALL be T5.
REQ-013 T5 SHALL assert Zlowout and Rin[Ra]; the next state SHALL be T0 if Run=1, else IDLE.
REQ-014 In T3, for NOP or undefined opcodes, T3 SHALL assert no strobes and SHALL exit like T5, to T0 if Run=1 else IDLE.
REQ-015 In T3, for HALT, no strobes SHALL be asserted and the next state SHALL be HALT.
REQ-016 HALT SHALL assert Halted only; it SHALL be left only by reset, regardless of Run.
REQ-017 Run=0 during T0..T4 SHALL NOT abort the instruction; Run SHALL be sampled only in IDLE, T5 and the NOP/undefined T3 exit.
REQ-018 Rout and Rin SHALL each have at most one bit set in any state, and both SHALL be all-zero outside T3/T4 (Rout) and T5 (Rin).
REQ-019 Read SHALL never be asserted outside T1.

Reset
REQ-020 Resetn=0 SHALL force the state to IDLE immediately, independent of Clock.
REQ-021 During reset, every strobe output SHALL be 0, Rout and Rin SHALL be 16'h0000, Running SHALL be 0 and Halted SHALL be 0.
REQ-022 A reset asserted mid-instruction (any T-state or HALT) SHALL abandon the instruction without completing any pending register write.
REQ-023 The first state after Resetn rises SHALL be IDLE, and T0 SHALL follow on the first rising edge with Run=1.

Verification
REQ-024 Reset: hold Resetn=0 with Run=1 and toggle Clock -> all outputs remain 0 and the state remains IDLE.
REQ-025 AND instruction: Run=1, Mem_ready=1, IR=32'h28918000 -> strobes follow T0..T5 in 6 cycles; Rout=16'h0004 with Yin in T3; Rout=16'h0008 with AND and Zin in T4; Rin=16'h0002 with Zlowout in T5.
REQ-026 Memory stall: hold Mem_ready=0 for 3 cycles in T1 -> T1 lasts 4 cycles with Read and MDRin continuously high, then T2 follows.
REQ-027 HALT: IR=32'hD8000000 -> T3 asserts no strobes, then Halted=1 indefinitely with Run=1; Resetn pulse -> IDLE.
REQ-028 Reset mid-operation: assert Resetn=0 during T4 of an ADD -> outputs drop to 0 asynchronously and no Rin pulse occurs.
REQ-029 Run drop: deassert Run during T2 of a SUB -> the instruction completes through T5, then the state goes to IDLE with Running=0.
